// File: rtl/rf_write_arbiter_if.sv
// Write-back requester channel: valid/ready handshake carrying rd and data.
interface rf_write_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              valid;
  logic              ready;
  logic [ADDR_W-1:0] rd;
  logic [DATA_W-1:0] data;

  modport master (
    output valid,
    output rd,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  rd,
    input  data,
    output ready
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// Two-slot write-back arbiter for the register file's single write port.
// Round-robin grant with an age override when both slots target one rd.
module rf_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  rf_write_arbiter_if.slave a,
  rf_write_arbiter_if.slave b,
  output logic              rf_le,
  output logic [ADDR_W-1:0] rf_rw,
  output logic [DATA_W-1:0] rf_pw,
  input  logic [ADDR_W-1:0] chk_ra,
  input  logic [ADDR_W-1:0] chk_rb,
  input  logic [ADDR_W-1:0] chk_rd,
  output logic              hazard,
  output logic              busy
);

  logic              av, bv;
  logic [ADDR_W-1:0] ard, brd;
  logic [DATA_W-1:0] adat, bdat;
  logic              a_old;
  logic              last_b;

  logic ga, gb;
  logic ld_a, ld_b;
  logic a_stay, b_stay;

  // Equal rd means write order matters, so age beats the pointer.
  always_comb begin
    ga = 1'b0;
    gb = 1'b0;
    if (av && bv) begin
      if (ard == brd) begin
        ga = a_old;
        gb = !a_old;
      end else begin
        ga = last_b;
        gb = !last_b;
      end
    end else begin
      ga = av;
      gb = bv;
    end
  end

  assign a.ready = !av || ga;
  assign b.ready = !bv || gb;

  // r0 handshakes complete but are dropped.
  assign ld_a = a.valid && a.ready && (a.rd != '0);
  assign ld_b = b.valid && b.ready && (b.rd != '0);

  assign a_stay = av && !ga;
  assign b_stay = bv && !gb;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      av     <= 1'b0;
      bv     <= 1'b0;
      ard    <= '0;
      brd    <= '0;
      adat   <= '0;
      bdat   <= '0;
      a_old  <= 1'b0;
      last_b <= 1'b1;
    end else begin
      av <= ld_a || a_stay;
      bv <= ld_b || b_stay;
      if (ld_a) begin
        ard  <= a.rd;
        adat <= a.data;
      end
      if (ld_b) begin
        brd  <= b.rd;
        bdat <= b.data;
      end
      if (ld_a && ld_b) begin
        a_old <= 1'b1;
      end else if (ld_a && b_stay) begin
        a_old <= 1'b0;
      end else if (ld_b && a_stay) begin
        a_old <= 1'b1;
      end
      if (ga) begin
        last_b <= 1'b0;
      end else if (gb) begin
        last_b <= 1'b1;
      end
    end
  end

  assign rf_le = ga || gb;

  always_comb begin
    rf_rw = '0;
    rf_pw = '0;
    if (ga) begin
      rf_rw = ard;
      rf_pw = adat;
    end else if (gb) begin
      rf_rw = brd;
      rf_pw = bdat;
    end
  end

  function automatic logic hit(input logic [ADDR_W-1:0] r);
    return (r != '0) &&
           (r == chk_ra || r == chk_rb || r == chk_rd);
  endfunction

  assign hazard = (av && hit(ard)) || (bv && hit(brd));
  assign busy   = av || bv;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter with a behavioural register file.
module tb_rf_write_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        rf_le;
  logic [4:0]  rf_rw;
  logic [31:0] rf_pw;
  logic [4:0]  chk_ra, chk_rb, chk_rd;
  logic        hazard, busy;

  int vecs = 0;
  int errs = 0;
  int ca, cb;

  logic [31:0] rf [32] = '{default: 32'h0};

  rf_write_arbiter_if #(.DATA_W(32), .ADDR_W(5)) a_if ();
  rf_write_arbiter_if #(.DATA_W(32), .ADDR_W(5)) b_if ();

  rf_write_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk    (clk),
    .reset  (reset),
    .a      (a_if.slave),
    .b      (b_if.slave),
    .rf_le  (rf_le),
    .rf_rw  (rf_rw),
    .rf_pw  (rf_pw),
    .chk_ra (chk_ra),
    .chk_rb (chk_rb),
    .chk_rd (chk_rd),
    .hazard (hazard),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (rf_le && rf_rw != 5'd0) rf[rf_rw] <= rf_pw;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic setA(input logic v, input logic [4:0] r,
                      input logic [31:0] d);
    a_if.valid = v;
    a_if.rd    = r;
    a_if.data  = d;
  endtask

  task automatic setB(input logic v, input logic [4:0] r,
                      input logic [31:0] d);
    b_if.valid = v;
    b_if.rd    = r;
    b_if.data  = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset  = 1'b1;
    chk_ra = '0;
    chk_rb = '0;
    chk_rd = '0;
    setA(0, 0, 0);
    setB(0, 0, 0);
    #2;
    chk("rst_le", rf_le, 0);
    chk("rst_rw", rf_rw, 0);
    chk("rst_pw", rf_pw, 0);
    chk("rst_ardy", a_if.ready, 1);
    chk("rst_brdy", b_if.ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_haz", hazard, 0);

    // A and B together, distinct rd: A first by reset pointer
    @(negedge clk);
    reset = 1'b0;
    setA(1, 5'd6, 32'd1);
    setB(1, 5'd16, 32'd2);
    @(negedge clk);
    setA(0, 0, 0);
    setB(0, 0, 0);
    #1;
    chk("ab_k1_le", rf_le, 1);
    chk("ab_k1_rw", rf_rw, 6);
    chk("ab_k1_pw", rf_pw, 1);
    chk("ab_k1_brdy", b_if.ready, 0);
    @(negedge clk);
    chk("ab_k2_rw", rf_rw, 16);
    chk("ab_k2_pw", rf_pw, 2);
    @(negedge clk);
    chk("ab_idle_le", rf_le, 0);
    chk("ab_rf6", rf[6], 1);
    chk("ab_rf16", rf[16], 2);

    // same rd: A older, so B's value lands last
    setA(1, 5'd17, 32'h11);
    setB(1, 5'd17, 32'h22);
    @(negedge clk);
    setA(0, 0, 0);
    setB(0, 0, 0);
    #1;
    chk("same_k1_rw", rf_rw, 17);
    chk("same_k1_pw", rf_pw, 32'h11);
    @(negedge clk);
    chk("same_k2_rw", rf_rw, 17);
    chk("same_k2_pw", rf_pw, 32'h22);
    @(negedge clk);
    chk("same_rf17", rf[17], 32'h22);

    // fairness: both held valid, distinct rd
    ca = 0;
    cb = 0;
    setA(1, 5'd7, 32'hA0);
    setB(1, 5'd20, 32'hB0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 5) begin
        setA(0, 0, 0);
        setB(0, 0, 0);
      end else begin
        a_if.data = 32'hA1 + i;
        b_if.data = 32'hB1 + i;
      end
      #1;
      chk($sformatf("rr_%0d_rw", i), rf_rw,
          (i % 2 == 0) ? 32'd7 : 32'd20);
      if (rf_le && rf_rw == 5'd7) ca++;
      if (rf_le && rf_rw == 5'd20) cb++;
    end
    chk("rr_cnt_a", ca, 3);
    chk("rr_cnt_b", cb, 3);
    for (int i = 0; i < 8 && busy; i++) @(negedge clk);
    chk("rr_drain", busy, 0);

    // A only
    setA(1, 5'd5, 32'hAA);
    #1;
    chk("aonly_rdy", a_if.ready, 1);
    @(negedge clk);
    setA(0, 0, 0);
    #1;
    chk("aonly_le", rf_le, 1);
    chk("aonly_rw", rf_rw, 5);
    chk("aonly_pw", rf_pw, 32'hAA);
    chk("aonly_busy", busy, 1);
    @(negedge clk);
    chk("aonly_rf5", rf[5], 32'hAA);
    chk("aonly_idle", rf_le, 0);

    // rd=0 is accepted and dropped
    setA(1, 5'd0, 32'h55);
    #1;
    chk("r0_rdy", a_if.ready, 1);
    @(negedge clk);
    setA(0, 0, 0);
    #1;
    chk("r0_le", rf_le, 0);
    chk("r0_haz", hazard, 0);
    chk("r0_busy", busy, 0);

    // hazard on a pending destination
    setB(1, 5'd18, 32'h99);
    chk_rb = 5'd18;
    #1;
    chk("hz_pre", hazard, 0);
    @(negedge clk);
    setB(0, 0, 0);
    #1;
    chk("hz_pend", hazard, 1);
    chk("hz_rw", rf_rw, 18);
    @(negedge clk);
    chk("hz_clear", hazard, 0);
    chk_rb = 5'd0;

    // reset with both slots full discards them
    setA(1, 5'd9, 32'h909);
    setB(1, 5'd10, 32'h1010);
    @(negedge clk);
    setA(0, 0, 0);
    setB(0, 0, 0);
    #1;
    chk("mid_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_le", rf_le, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_after_le", rf_le, 0);
    @(negedge clk);
    chk("mid_after_le2", rf_le, 0);
    chk("mid_rf9", rf[9], 0);
    chk("mid_rf10", rf[10], 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the single write port (PW/RW/LE) of the 32x32 three-port register file between two write-back requesters: A (ALU result) and B (load data).
- Each requester has a one-entry holding slot with a valid/ready handshake.
- A round-robin grant, with an age override for same-register ordering, picks one slot per cycle to drive the write port.
- Provides a combinational read-after-write hazard flag for pending (buffered, not yet written) destinations.

Parameters:
- DATA_W, 32, width of write data (matches PW).
- ADDR_W, 5, width of register number (matches RW/RA/RB/RD).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- a_valid  in  1  requester A has a write.
- a_ready  out  1  A's write is accepted at this posedge if a_valid=1.
- a_rd  in  ADDR_W  A destination register.
- a_data  in  DATA_W  A write data.
- b_valid  in  1  requester B has a write.
- b_ready  out  1  B's write is accepted at this posedge if b_valid=1.
- b_rd  in  ADDR_W  B destination register.
- b_data  in  DATA_W  B write data.
- rf_le  out  1  to register file LE.
- rf_rw  out  ADDR_W  to register file RW.
- rf_pw  out  DATA_W  to register file PW.
- chk_ra  in  ADDR_W  source register numbers checked for a hazard.
- chk_rb  in  ADDR_W  (as chk_ra).
- chk_rd  in  ADDR_W  (as chk_ra).
- hazard  out  1  a pending slot targets a checked register.
- busy  out  1  at least one slot occupied.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high, named reset.
- Reset state:
  - Both slots empty; age flag cleared.
  - Round-robin pointer set to "last grant = B", so A wins the first contested cycle.
  - With slots empty: rf_le=0, rf_rw=0, rf_pw=0, hazard=0, busy=0, a_ready=1, b_ready=1.
- Reset mid-operation: buffered writes are discarded. No rf_le pulse occurs for them.
- Slot state: valid bit, rd, data. Storage is loaded only on a handshake.
- Handshake:
  - a_ready = !slotA_v | grantA. b_ready is the same for B.
  - Ready does not depend on a_valid or b_valid, so there is no combinational loop.
  - A slot granted this cycle may reload at the same edge; this gives full throughput of one write per cycle per requester when uncontended.
- Register zero: a handshake with rd=0 completes normally (ready obeyed) but the slot is not loaded. %r0 is never written and never raises hazard.
- Grant is combinational from slot state only:
  - One slot occupied: grant it.
  - Both occupied, rd differ: round-robin; grant the slot not granted last.
  - Both occupied, rd equal: grant the older slot (age flag), regardless of the pointer.
  - Pointer updates on every grant.
- Age rules:
  - A slot loaded while the other slot stays occupied is younger.
  - Both loaded at the same edge: A is older, so B's value is final for equal rd.
- Write port:
  - rf_le = grantA | grantB.
  - rf_rw and rf_pw come from the granted slot; both are 0 when there is no grant.
  - The granted slot clears at the posedge, the same edge at which the register file captures.
- Latency: a write accepted at edge k is written to the register file at edge k+1 if uncontended, or at the latest at edge k+2.
- hazard = OR over occupied slots of (slot_rd == chk_ra | chk_rb | chk_rd) with slot_rd != 0. A slot being written this cycle still counts.
- busy = slotA_v | slotB_v.

Test Plan:
- Reset, idle → rf_le=0, a_ready=b_ready=1, busy=0. Assert reset while both slots are full → slots cleared asynchronously, no rf_le afterwards.
- A only: a_rd=5, a_data=0x0000_00AA for one cycle → next cycle rf_le=1, rf_rw=5, rf_pw=0xAA. Register file reading RA=5 returns 0xAA after that edge.
- A and B same edge: a_rd=6 data=1, b_rd=16 data=2 → cycle k+1 writes r6 (A, pointer default), cycle k+2 writes r16. b_ready=0 during k+1.
- Same rd ordering: a_rd=17 data=0x11 and b_rd=17 data=0x22 at the same edge → r17=0x11 is written first, then 0x22; final r17=0x22.
- Round-robin fairness: hold a_valid=b_valid=1 with distinct rd for 6 cycles → grants alternate B,A,B,A… after the first A; each requester gets exactly 3 writes.
- Zero/hazard:
  - a_rd=0 → a_ready=1, no rf_le, hazard=0.
  - Pending slot rd=18 with chk_rb=18 → hazard=1.
  - After its write edge, with no new load, hazard=0.
